// File: rtl/rot_aligner_if.sv
// Stream and status bundle between a rotated-byte source and rot_aligner.
// ROT_ALIGNER_STATS_EN adds the slip_cnt status field.
interface rot_aligner_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       locked;
  logic [2:0] amt;
  logic       sync_det;
`ifdef ROT_ALIGNER_STATS_EN
  logic [15:0] slip_cnt;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, locked, amt, sync_det, slip_cnt
  );
  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, locked, amt, sync_det, slip_cnt
  );
`else
  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, locked, amt, sync_det
  );
  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, locked, amt, sync_det
  );
`endif
endinterface

// File: rtl/rot_aligner.sv
// Finds the unknown right-rotation of a framed byte stream from its sync byte, locks, restores payload.
// Latency: in_valid -> out_valid 1 cycle, every output registered. ROT_ALIGNER_STATS_EN adds slip_cnt.
// Backpressure: none; in_valid low freezes all state and forwards nothing.
module rot_aligner #(
  parameter int         W         = 8,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         FRAME_LEN = 16,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 2
) (
  input logic        clk,
  input logic        rst_n,
  rot_aligner_if.slave io
);

  localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_inc;
  logic [2:0]    amt_q, amt_d;
  logic [7:0]    good_q, good_d;
  logic [7:0]    miss_q, miss_d;
  logic [W-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic          lock_q, lock_d;
  logic          det_q, det_d;
  logic          any_hit, amt_hit, at_hdr;
  logic [2:0]    hit_r;
`ifdef ROT_ALIGNER_STATS_EN
  logic [15:0]   slip_q, slip_d;
`endif

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [2:0] r);
    logic [2*W-1:0] t;
    t = {x, x} >> r;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [2:0] r);
    logic [2*W-1:0] t;
    t = {x, x} << r;
    return t[2*W-1:W];
  endfunction

  // All 8 rotations of SYNC are distinct, so at most one candidate hits.
  always_comb begin
    any_hit = 1'b0;
    hit_r   = '0;
    for (int i = 0; i < 8; i++) begin
      if (io.in_data == rotr(SYNC, 3'(i))) begin
        any_hit = 1'b1;
        hit_r   = 3'(i);
      end
    end
  end

  assign amt_hit = (io.in_data == rotr(SYNC, amt_q));
  assign at_hdr  = (pos_q == '0);
  assign pos_inc = (pos_q == PW'(FRAME_LEN - 1)) ? '0 : pos_q + PW'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    amt_d   = amt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    lock_d  = lock_q;
    det_d   = 1'b0;
`ifdef ROT_ALIGNER_STATS_EN
    slip_d  = slip_q;
`endif
    if (io.in_valid) begin
      case (state_q)
        SEARCH: begin
          if (any_hit) begin
            amt_d   = hit_r;
            good_d  = 8'd1;
            miss_d  = '0;
            pos_d   = PW'(1);
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (at_hdr) begin
            if (amt_hit) begin
              good_d = good_q + 8'd1;
              det_d  = 1'b1;
              if (good_d == 8'(LOCK_CNT)) begin
                state_d = LOCKED;
                lock_d  = 1'b1;
              end
            end else begin
              // The failing byte is dropped, not retried as a new candidate.
              state_d = SEARCH;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_inc;
          if (!at_hdr) begin
            vld_d  = 1'b1;
            data_d = rotl(io.in_data, amt_q);
          end else if (amt_hit) begin
            miss_d = '0;
            det_d  = 1'b1;
          end else if (miss_q + 8'd1 == 8'(LOSS_CNT)) begin
            state_d = SEARCH;
            lock_d  = 1'b0;
            miss_d  = '0;
`ifdef ROT_ALIGNER_STATS_EN
            if (slip_q != 16'hFFFF) slip_d = slip_q + 16'd1;
`endif
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      pos_q   <= '0;
      amt_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
      det_q   <= 1'b0;
`ifdef ROT_ALIGNER_STATS_EN
      slip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      amt_q   <= amt_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      det_q   <= det_d;
`ifdef ROT_ALIGNER_STATS_EN
      slip_q  <= slip_d;
`endif
    end
  end

  assign io.out_valid = vld_q;
  assign io.out_data  = data_q;
  assign io.locked    = lock_q;
  assign io.amt       = amt_q;
  assign io.sync_det  = det_q;
`ifdef ROT_ALIGNER_STATS_EN
  assign io.slip_cnt  = slip_q;
`endif

endmodule
